// File: rtl/prime_gen_pkg.sv
// Shared definitions for the prime search engine: default width and FSM states.
package prime_gen_pkg;

  localparam int PRIME_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MOD   = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/prime_gen.sv
// Iterative prime search: finds the smallest prime >= max(seed,2) by trial
// division, where each remainder is formed by repeated subtraction, one per
// cycle. Latency depends on the data by design.
module prime_gen
  import prime_gen_pkg::*;
#(
  parameter int W = PRIME_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] seed,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [W-1:0] prime,
  output logic [15:0]  cycle_cnt
);

  state_t state, state_nx;

  logic [W-1:0]   cand;
  logic [W-1:0]   d;
  logic [W-1:0]   rem;
  logic [2*W-1:0] d_wide;
  logic [2*W-1:0] d_sq;
  logic [2*W-1:0] cand_wide;
  logic           sq_gt;
  logic           rem_lt;
  logic           rem_zero;
  logic           cand_max;
  logic           accept;

  // Saturating increment for the cycle counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The square is formed at double width so it can never wrap.
  assign d_wide    = {{W{1'b0}}, d};
  assign d_sq      = d_wide * d_wide;
  assign cand_wide = {{W{1'b0}}, cand};
  assign sq_gt     = (d_sq > cand_wide);
  assign rem_lt    = (rem < d);
  assign rem_zero  = (rem == '0);
  assign cand_max  = (cand == {W{1'b1}});
  assign accept    = (state == S_IDLE) && start;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; start is only looked at in IDLE, so it never queues.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = sq_gt ? S_DONE : S_MOD;
      S_MOD:   if (rem_lt) state_nx = rem_zero ? S_NEXT : S_CHECK;
      S_NEXT:  state_nx = cand_max ? S_DONE : S_CHECK;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Candidate under test: loaded from the seed (floored at 2), stepped on a factor hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
    end else if (accept) begin
      cand <= (seed < W'(2)) ? W'(2) : seed;
    end else if (state == S_NEXT && !cand_max) begin
      cand <= cand + W'(1);
    end
  end

  // Trial divisor: restarts at 2 per candidate, advances when a remainder is nonzero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
    end else if (accept) begin
      d <= W'(2);
    end else if (state == S_MOD && rem_lt && !rem_zero) begin
      d <= d + W'(1);
    end else if (state == S_NEXT && !cand_max) begin
      d <= W'(2);
    end
  end

  // Running remainder: reloaded with the candidate, then reduced by d each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
    end else if (state == S_CHECK && !sq_gt) begin
      rem <= cand;
    end else if (state == S_MOD && !rem_lt) begin
      rem <= rem - d;
    end
  end

  // Result registers: cleared on a new search, written once on the way to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime <= '0;
      found <= 1'b0;
    end else if (accept) begin
      prime <= '0;
      found <= 1'b0;
    end else if (state == S_CHECK && sq_gt) begin
      prime <= cand;
      found <= 1'b1;
    end else if (state == S_NEXT && cand_max) begin
      prime <= '0;
      found <= 1'b0;
    end
  end

  // Work-cycle counter: counts CHECK, MOD and NEXT cycles of the current search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
    end else if (state == S_CHECK || state == S_MOD || state == S_NEXT) begin
      cycle_cnt <= sat_inc(cycle_cnt);
    end
  end

endmodule

// File: tb/tb_prime_gen.sv
// Testbench for prime_gen: directed cases plus random seeds against an
// arithmetic reference model of the search result and its cycle cost.
module tb_prime_gen;

  localparam int W      = 8;
  localparam int MAXC   = (1 << W) - 1;
  localparam int BUDGET = 20000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] seed;
  logic         busy;
  logic         done;
  logic         found;
  logic [W-1:0] prime;
  logic [15:0]  cycle_cnt;

  int tests;
  int fails;

  prime_gen #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .prime     (prime),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
  endtask

  // Smallest prime >= max(s,2) by plain trial division; the cycle cost is
  // derived from the rules: testing divisor d on candidate c costs one
  // check plus floor(c/d) subtractions plus the final remainder cycle; a
  // prime costs one more check, a composite one step to the next candidate.
  task automatic ref_model(input int s, output int p, output int f, output int cyc);
    int  c;
    bit  is_p;
    bit  fin;
    c   = (s < 2) ? 2 : s;
    cyc = 0;
    fin = 0;
    p   = 0;
    f   = 0;
    while (!fin) begin
      is_p = 1;
      for (int dv = 2; dv * dv <= c; dv++) begin
        cyc += 2 + c / dv;
        if (c % dv == 0) begin
          is_p = 0;
          break;
        end
      end
      cyc += 1;
      if (is_p) begin
        p = c; f = 1; fin = 1;
      end else if (c == MAXC) begin
        p = 0; f = 0; fin = 1;
      end else begin
        c++;
      end
    end
    if (cyc > 65535) cyc = 65535;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one search; optionally re-pulses start (seed=3) while busy.
  task automatic search(input int s, input bit poke, output int rp, output int rf, output int rc);
    int cyc;
    int extra;
    bit got;
    int ep, ef, ec;
    ref_model(s, ep, ef, ec);
    seed  = W'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("busy_after_start_%0d", s), busy, 1);
    cyc = 0;
    got = done;
    while (!got && cyc < BUDGET) begin
      start = (poke && cyc == 3);
      if (start) seed = W'(3);
      tick();
      start = 1'b0;
      cyc++;
      got = done;
    end
    chk($sformatf("done_seen_%0d", s), got, 1);
    rp = prime;
    rf = found;
    rc = cycle_cnt;
    chk($sformatf("prime_%0d", s), prime, ep);
    chk($sformatf("found_%0d", s), found, ef);
    chk($sformatf("cycles_%0d", s), cycle_cnt, ec);
    tick();
    chk($sformatf("done_one_cycle_%0d", s), done, 0);
    chk($sformatf("idle_after_done_%0d", s), busy, 0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) extra++;
    end
    chk($sformatf("no_extra_done_%0d", s), extra, 0);
    chk($sformatf("prime_held_%0d", s), prime, rp);
    chk($sformatf("cycles_held_%0d", s), cycle_cnt, rc);
  endtask

  initial begin
    int p, f, c;
    int seen;
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    start = 1'b0;
    seed  = '0;

    // Reset values, checked while reset is still asserted
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_prime", prime, 0);
    chk("rst_cycles", cycle_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("idle_holds", busy, 0);

    // Directed values
    search(7, 0, p, f, c);
    chk("seed7_prime", p, 7);
    chk("seed7_cycles", c, 6);
    search(0, 0, p, f, c);
    chk("seed0_prime", p, 2);
    chk("seed0_cycles", c, 1);
    search(1, 0, p, f, c);
    chk("seed1_prime", p, 2);
    chk("seed1_cycles", c, 1);
    search(8, 0, p, f, c);
    chk("seed8_prime", p, 11);
    search(251, 0, p, f, c);
    chk("seed251_prime", p, 251);
    chk("seed251_found", f, 1);
    search(252, 0, p, f, c);
    chk("seed252_found", f, 0);
    chk("seed252_prime", p, 0);

    // start while busy must be ignored
    search(200, 1, p, f, c);
    chk("busy_start_prime", p, 211);

    // Reset in the middle of a search
    seed  = W'(200);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_found", found, 0);
    chk("midrst_prime", prime, 0);
    chk("midrst_cycles", cycle_cnt, 0);
    tick();
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) seen++;
    end
    chk("midrst_no_done", seen, 0);
    search(13, 0, p, f, c);
    chk("after_rst_prime", p, 13);

    // Random seeds against the model
    for (int i = 0; i < 20; i++) begin
      search(int'($urandom_range(0, MAXC)), 0, p, f, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
